// File: rtl/innings_controller.sv
// ---------------------------------------------------------------------------
// innings_controller
// Match sequencer for a T20 game. It tells the scoring block which side is
// batting and how many legal balls each side has faced, and it raises
// game_over when the match ends. It reads the team runs and wickets back
// from the scoring block to decide when each innings ends. It latches the
// chase target, stops the chase as soon as the target is reached, and
// declares the winner. It also supplies over/ball values for the display.
//
// Ports
//   clk            system clock
//   rst            asynchronous, active-high reset
//   play           run enable; low pauses ball counting and the break timer
//   extra          wide/no-ball on this delivery (not a legal ball)
//   team1_runs     team 1 total from the scoring block
//   team2_runs     team 2 total from the scoring block
//   team1_wickets  team 1 wickets from the scoring block
//   team2_wickets  team 2 wickets from the scoring block
//   team           batting side (0 = team 1, 1 = team 2)
//   team_1_ball    team 1 legal balls bowled
//   team_2_ball    team 2 legal balls bowled
//   game_over      match finished; held until rst
//   innings_break  high while between innings
//   target         team 1 runs + 1, latched at the end of innings 1
//   winner         00 undecided, 01 team 1, 10 team 2, 11 tie
//   over_num       completed overs of the batting side
//   ball_in_over   legal balls in the current over
// ---------------------------------------------------------------------------
module innings_controller #(
    parameter int MAX_BALLS      = 120,
    parameter int MAX_WICKETS    = 10,
    parameter int BALLS_PER_OVER = 6,
    parameter int BREAK_CYCLES   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       play,
    input  logic       extra,
    input  logic [7:0] team1_runs,
    input  logic [7:0] team2_runs,
    input  logic [3:0] team1_wickets,
    input  logic [3:0] team2_wickets,
    output logic       team,
    output logic [6:0] team_1_ball,
    output logic [6:0] team_2_ball,
    output logic       game_over,
    output logic       innings_break,
    output logic [8:0] target,
    output logic [1:0] winner,
    output logic [4:0] over_num,
    output logic [2:0] ball_in_over
);

    localparam int         TW        = (BREAK_CYCLES > 2) ? $clog2(BREAK_CYCLES) : 1;
    localparam logic [6:0] MAX_B     = 7'(MAX_BALLS);
    localparam logic [3:0] MAX_W     = 4'(MAX_WICKETS);
    localparam logic [2:0] BPO_LAST  = 3'(BALLS_PER_OVER - 1);
    localparam logic [TW-1:0] BRK_LAST = TW'(BREAK_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INN1  = 3'd1,
        S_BREAK = 3'd2,
        S_INN2  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t        r_state, w_state_nxt;
    logic          r_team, w_team;
    logic [6:0]    r_t1_ball, w_t1_ball;
    logic [6:0]    r_t2_ball, w_t2_ball;
    logic          r_game_over, w_game_over;
    logic          r_break, w_break;
    logic [8:0]    r_target, w_target;
    logic [1:0]    r_winner, w_winner;
    logic [4:0]    r_over, w_over;
    logic [2:0]    r_bio, w_bio;
    logic [TW-1:0] r_timer, w_timer;

    logic          w_legal;
    logic [2:0]    w_bio_adv;
    logic [4:0]    w_over_adv;

    // A legal ball is counted only while running and not an extra.
    assign w_legal    = play & ~extra;
    // The ball-in-over count wraps at the end of an over and bumps the over count.
    assign w_bio_adv  = (r_bio == BPO_LAST) ? 3'd0 : (r_bio + 3'd1);
    assign w_over_adv = (r_bio == BPO_LAST) ? (r_over + 5'd1) : r_over;

    // Next-state and next-output logic; every register holds unless a state updates it.
    always_comb begin
        w_state_nxt = r_state;
        w_team      = r_team;
        w_t1_ball   = r_t1_ball;
        w_t2_ball   = r_t2_ball;
        w_game_over = r_game_over;
        w_break     = r_break;
        w_target    = r_target;
        w_winner    = r_winner;
        w_over      = r_over;
        w_bio       = r_bio;
        w_timer     = r_timer;

        case (r_state)
            S_IDLE: begin
                w_team = 1'b0;
                if (play) begin
                    w_state_nxt = S_INN1;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end

            S_INN1: begin
                if ((r_t1_ball == MAX_B) || (team1_wickets >= MAX_W)) begin
                    w_state_nxt = S_BREAK;
                    w_target    = {1'b0, team1_runs} + 9'd1;
                    w_over      = 5'd0;
                    w_bio       = 3'd0;
                    w_break     = 1'b1;
                    w_timer     = '0;
                end else if (w_legal) begin
                    w_t1_ball = r_t1_ball + 7'd1;
                    w_bio     = w_bio_adv;
                    w_over    = w_over_adv;
                end else begin
                    w_state_nxt = S_INN1;
                end
            end

            S_BREAK: begin
                w_break = 1'b1;
                w_team  = 1'b0;
                if (play) begin
                    if (r_timer == BRK_LAST) begin
                        w_team      = 1'b1;
                        w_timer     = '0;
                        w_break     = 1'b0;
                        w_state_nxt = S_INN2;
                    end else begin
                        w_timer = r_timer + TW'(1);
                    end
                end else begin
                    w_timer = r_timer;
                end
            end

            S_INN2: begin
                // Reaching the target takes priority, so a winning final ball still wins.
                if ({1'b0, team2_runs} >= r_target) begin
                    w_winner    = 2'b10;
                    w_game_over = 1'b1;
                    w_state_nxt = S_DONE;
                end else if ((r_t2_ball == MAX_B) || (team2_wickets >= MAX_W)) begin
                    if (team1_runs > team2_runs) begin
                        w_winner = 2'b01;
                    end else begin
                        w_winner = 2'b11;
                    end
                    w_game_over = 1'b1;
                    w_state_nxt = S_DONE;
                end else if (w_legal) begin
                    w_t2_ball = r_t2_ball + 7'd1;
                    w_bio     = w_bio_adv;
                    w_over    = w_over_adv;
                end else begin
                    w_state_nxt = S_INN2;
                end
            end

            S_DONE: begin
                w_game_over = 1'b1;
                w_state_nxt = S_DONE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Output and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_team      <= 1'b0;
            r_t1_ball   <= 7'd0;
            r_t2_ball   <= 7'd0;
            r_game_over <= 1'b0;
            r_break     <= 1'b0;
            r_target    <= 9'd0;
            r_winner    <= 2'b00;
            r_over      <= 5'd0;
            r_bio       <= 3'd0;
            r_timer     <= '0;
        end else begin
            r_team      <= w_team;
            r_t1_ball   <= w_t1_ball;
            r_t2_ball   <= w_t2_ball;
            r_game_over <= w_game_over;
            r_break     <= w_break;
            r_target    <= w_target;
            r_winner    <= w_winner;
            r_over      <= w_over;
            r_bio       <= w_bio;
            r_timer     <= w_timer;
        end
    end

    assign team          = r_team;
    assign team_1_ball   = r_t1_ball;
    assign team_2_ball   = r_t2_ball;
    assign game_over     = r_game_over;
    assign innings_break = r_break;
    assign target        = r_target;
    assign winner        = r_winner;
    assign over_num      = r_over;
    assign ball_in_over  = r_bio;

endmodule
